// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings,
// the per-beat flag bundle and small op-decoding helpers.
package addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_ADDS = 2'd2;
    localparam logic [1:0] OP_SUBS = 2'd3;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic neg;
    } flags_t;

    function automatic logic is_sub_op(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SUBS);
    endfunction

    function automatic logic is_sat_op(input logic [1:0] op);
        return (op == OP_ADDS) || (op == OP_SUBS);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// One registered SW-bit carry-chain slice; also reports the carry into its
// top bit so the most significant slice can derive signed overflow.
module addsub_slice #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid_in,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic          valid_out,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);
    import addsub_pkg::*;

    logic [SW:0] total;
    logic        cmsb_next;

    always_comb begin
        total     = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
        cmsb_next = total[SW-1] ^ a[SW-1] ^ b[SW-1];
    end

    // Data only follows valid beats so a bubble never disturbs a held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            cmsb      <= 1'b0;
        end else if (en) begin
            valid_out <= valid_in;
            if (valid_in) begin
                sum  <= total[SW-1:0];
                cout <= total[SW];
                cmsb <= cmsb_next;
            end
        end
    end

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with optional signed saturation. The carry chain is
// cut into STAGES slices; slice k resolves in stage k with its carry registered.
module addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);
    import addsub_pkg::*;

    localparam int SW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "addsub_pipe: WIDTH must be within 8..64");
    end
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_stages
        $fatal(1, "addsub_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic              advance;
    logic              sub_in;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] cout_s;
    logic              cmsb_s    [STAGES];
    logic [SW-1:0]     slice_sum [STAGES];
    logic [SW-1:0]     fin       [STAGES];
    logic [1:0]        op_r      [STAGES];
    logic              loaded;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  sat_sum;
    logic              ovf_raw;
    flags_t            flags;

    // The whole pipeline moves as one; only a refused result freezes it.
    assign advance  = !valid_s[STAGES-1] || out_ready;
    assign in_ready = rst_n && advance;
    assign sub_in   = is_sub_op(op);
    assign b_eff    = sub_in ? ~b : b;

    always_comb begin
        vin[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = valid_s[k-1];
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_chunk
        logic [SW-1:0] a_c;
        logic [SW-1:0] b_c;
        logic          c_in;

        if (j == 0) begin : g_direct
            assign a_c  = a[SW-1:0];
            assign b_c  = b_eff[SW-1:0];
            assign c_in = sub_in;
        end else begin : g_delay
            // Upper operand chunks wait j stages until their slice's turn.
            logic [SW-1:0] a_r [1:j];
            logic [SW-1:0] b_r [1:j];

            always_ff @(posedge clk) begin
                if (advance && vin[0]) begin
                    a_r[1] <= a[j*SW +: SW];
                    b_r[1] <= b_eff[j*SW +: SW];
                end
                for (int i = 2; i <= j; i++) begin
                    if (advance && vin[i-1]) begin
                        a_r[i] <= a_r[i-1];
                        b_r[i] <= b_r[i-1];
                    end
                end
            end

            assign a_c  = a_r[j];
            assign b_c  = b_r[j];
            assign c_in = cout_s[j-1];
        end

        addsub_slice #(
            .SW(SW)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (advance),
            .valid_in  (vin[j]),
            .a         (a_c),
            .b         (b_c),
            .cin       (c_in),
            .valid_out (valid_s[j]),
            .sum       (slice_sum[j]),
            .cout      (cout_s[j]),
            .cmsb      (cmsb_s[j])
        );

        if (j == STAGES - 1) begin : g_last
            assign fin[j] = slice_sum[j];
        end else begin : g_align
            // Resolved lower chunks ride along until the top slice catches up.
            logic [SW-1:0] s_r [1:STAGES-1-j];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 1; i <= STAGES - 1 - j; i++) begin
                        s_r[i] <= '0;
                    end
                end else begin
                    if (advance && vin[j+1]) begin
                        s_r[1] <= slice_sum[j];
                    end
                    for (int i = 2; i <= STAGES - 1 - j; i++) begin
                        if (advance && vin[j+i]) begin
                            s_r[i] <= s_r[i-1];
                        end
                    end
                end
            end

            assign fin[j] = s_r[STAGES-1-j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                op_r[k] <= OP_ADD;
            end
            loaded <= 1'b0;
        end else begin
            if (advance && vin[0]) begin
                op_r[0] <= op;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (advance && vin[k]) begin
                    op_r[k] <= op_r[k-1];
                end
            end
            if (advance && vin[STAGES-1]) begin
                loaded <= 1'b1;
            end
        end
    end

    // Zero is qualified by 'loaded' so the post-reset all-zero result reads as no flags.
    always_comb begin
        raw = '0;
        for (int k = 0; k < STAGES; k++) begin
            raw[k*SW +: SW] = fin[k];
        end
        ovf_raw = cmsb_s[STAGES-1] ^ cout_s[STAGES-1];
        sat_sum = raw;
        if (ovf_raw && is_sat_op(op_r[STAGES-1])) begin
            sat_sum = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
        end
        flags.cout     = cout_s[STAGES-1];
        flags.overflow = ovf_raw;
        flags.zero     = loaded && (sat_sum == '0);
        flags.neg      = sat_sum[WIDTH-1];
    end

    assign out_valid = valid_s[STAGES-1];
    assign sum       = sat_sum;
    assign cout      = flags.cout;
    assign overflow  = flags.overflow;
    assign zero      = flags.zero;
    assign neg       = flags.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, STAGES=4) against an
// arithmetic reference model and a result queue.
module tb_addsub_pipe;
    import addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic        neg;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q [$];

    always #5 clk = ~clk;

    addsub_pipe #(
        .WIDTH  (32),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .neg       (neg)
    );

    // Result packed as {sum, cout, overflow, zero, neg}, from exact integer arithmetic.
    function automatic logic [35:0] ref_model(input logic [31:0] x, input logic [31:0] y,
                                              input logic [1:0] o);
        longint      sx, sy, ux, uy, exact, raw;
        logic        ovf, carry;
        logic [31:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        if (o == OP_SUB || o == OP_SUBS) begin
            exact = sx - sy;
            raw   = ux - uy;
            carry = (ux >= uy);
        end else begin
            exact = sx + sy;
            raw   = ux + uy;
            carry = raw[32];
        end
        ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        res = raw[31:0];
        if (ovf && (o == OP_ADDS || o == OP_SUBS)) begin
            res = (exact > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        return {res, carry, ovf, (res == 32'd0), res[31]};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; op = OP_ADD;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        total++;
        if ({out_valid, sum, cout, overflow, zero, neg} !== 37'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {out_valid, sum, cout, overflow, zero, neg});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'h8000_0000,
                                32'h7FFF_FFF0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd3};
        logic [31:0] vb [8] = '{32'd1, 32'd5, 32'd1, 32'd1,
                                32'h20, 32'd1, 32'hFFFF_FFFF, 32'd4};
        logic [1:0]  vo [8] = '{OP_ADD, OP_SUB, OP_SUB, OP_SUBS,
                                OP_ADDS, OP_ADD, OP_SUBS, OP_ADDS};
        logic [31:0] es [8] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd7};
        logic [35:0] exp_v;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            a         = va[i];
            b         = vb[i];
            op        = vo[i];
            out_ready = 1'b1;
            exp_v     = ref_model(va[i], vb[i], vo[i]);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL dir%0d_in_ready: got %b expected 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                if (k > 1) begin
                    @(posedge clk);
                    #1;
                end
                total++;
                if (out_valid !== (k == 4)) begin
                    bad++;
                    $display("[TB] FAIL dir%0d_latency c%0d: got %b expected %b",
                             i, k, out_valid, (k == 4));
                end
            end
            total++;
            if ({sum, cout, overflow, zero, neg} !== exp_v) begin
                bad++;
                $display("[TB] FAIL dir%0d_result: got %h expected %h",
                         i, {sum, cout, overflow, zero, neg}, exp_v);
            end
            total++;
            if (sum !== es[i]) begin
                bad++;
                $display("[TB] FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [16];
        logic [31:0] tb_ [16];
        logic [1:0]  to [16];
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        stall;
        logic [35:0] exp_v;
        for (int i = 0; i < 16; i++) begin
            ta[i]  = $urandom;
            tb_[i] = $urandom;
            to[i]  = 2'($urandom_range(3));
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        while (got < 16 && cyc < 100) begin
            stall     = (cyc >= 6 && cyc <= 9);
            out_ready = !stall;
            in_valid  = (sent < 16);
            if (sent < 16) begin
                a  = ta[sent];
                b  = tb_[sent];
                op = to[sent];
            end
            #1;
            total++;
            if (in_ready !== !stall) begin
                bad++;
                $display("[TB] FAIL b2b_in_ready c%0d: got %b expected %b", cyc, in_ready, !stall);
            end
            if (stall) begin
                total++;
                if (exp_q.size() == 0 ||
                    {out_valid, sum, cout, overflow, zero, neg} !== {1'b1, exp_q[0]}) begin
                    bad++;
                    $display("[TB] FAIL b2b_frozen c%0d: got %h expected %h", cyc,
                             {out_valid, sum, cout, overflow, zero, neg},
                             (exp_q.size() == 0) ? 37'd0 : {1'b1, exp_q[0]});
                end
            end else if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_spurious c%0d: got %h expected no beat", cyc, sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    got++;
                    if ({sum, cout, overflow, zero, neg} !== exp_v) begin
                        bad++;
                        $display("[TB] FAIL b2b_result beat%0d: got %h expected %h",
                                 got - 1, {sum, cout, overflow, zero, neg}, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, op));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (got != 16) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d expected 16", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_bubbles();
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic [35:0] exp_v;
        exp_q.delete();
        while ((got < 24) && cyc < 400) begin
            in_valid  = (sent < 24) && ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(3));
            #1;
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL bub_spurious c%0d: got %h expected no beat", cyc, sum);
                end else if ({sum, cout, overflow, zero, neg} !== exp_q[0]) begin
                    bad++;
                    $display("[TB] FAIL bub_result c%0d: got %h expected %h", cyc,
                             {sum, cout, overflow, zero, neg}, exp_q[0]);
                end
                if (out_ready && exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, op));
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        total++;
        if (got != 24 || exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL bub_count: got %0d expected 24", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [35:0] exp_v;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(3));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_in_ready_rst: got %b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        total++;
        if ({out_valid, sum, cout, overflow, zero, neg} !== 37'd0) begin
            bad++;
            $display("[TB] FAIL mid_outputs_cleared: got %h expected 0",
                     {out_valid, sum, cout, overflow, zero, neg});
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_in_ready_release: got %b expected 1", in_ready);
        end
        in_valid = 1'b1;
        a  = 32'h4000_0000;
        b  = 32'hC000_0001;
        op = OP_SUBS;
        exp_v = ref_model(a, b, op);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            total++;
            if (out_valid !== (k == 4)) begin
                bad++;
                $display("[TB] FAIL mid_valid c%0d: got %b expected %b", k, out_valid, (k == 4));
            end
            if (k == 4) begin
                total++;
                if ({sum, cout, overflow, zero, neg} !== exp_v) begin
                    bad++;
                    $display("[TB] FAIL mid_result: got %h expected %h",
                             {sum, cout, overflow, zero, neg}, exp_v);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a  = '0;
        b  = '0;
        op = OP_ADD;
        test_reset();
        test_directed();
        test_back_to_back();
        test_bubbles();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter STAGES, default 4, number of pipeline slices; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  operation: 0 ADD, 1 SUB, 2 ADDS (signed saturating add), 3 SUBS (signed saturating subtract).
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB; for SUB/SUBS 1 = no borrow.
REQ-014 overflow  output  1  signed overflow of unsaturated result.
REQ-015 zero  output  1  sum equals 0 (after saturation).
REQ-016 neg  output  1  sum[WIDTH-1] (after saturation).

Function
REQ-017 Subtract SHALL be computed as A + ~B + 1; add as A + B + 0.
REQ-018 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k resolves in pipeline stage k, carry registered between stages; operand upper bits and op delayed alongside.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted input beat (in_valid && in_ready) to out_valid, absent back-pressure.
REQ-020 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-021 overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-022 For ADDS/SUBS with overflow=1, sum SHALL be 0x7F..F if the unsaturated MSB is 1, else 0x80..0; overflow still reported as 1; cout unaffected by saturation.
REQ-023 For ADD/SUB, sum SHALL be the raw WIDTH-bit wrap-around result.
REQ-024 Flags SHALL belong to the same beat as sum and change only when out_valid is presented for a new beat.
REQ-025 Stall: when out_valid=1 and out_ready=0, the entire pipeline SHALL hold, in_ready SHALL be 0, outputs SHALL remain stable.
REQ-026 in_ready SHALL be 1 whenever out_valid=0 or out_ready=1 (combinational from out_ready; no skid buffer).
REQ-027 Pipeline bubbles SHALL propagate as invalid stages; a bubble at the output SHALL not stall upstream.
REQ-028 Beats SHALL exit in acceptance order; none dropped or duplicated.
REQ-029 Simultaneous output accept and input accept in one cycle SHALL both take effect.

Reset
REQ-030 While rst_n=0 at a rising clk edge, all stage valid bits SHALL clear; out_valid=0, sum=0, cout=0, overflow=0, zero=0, neg=0 from the following cycle.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; none appear after release.
REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-033 Datapath registers other than outputs need no reset.

Structure
REQ-034 Package addsub_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_ADDS, OP_SUBS) and the beat/flag struct typedef.
REQ-035 Sub-module addsub_slice SHALL implement one registered WIDTH/STAGES-bit carry-chain slice with carry in/out and valid/enable; addsub_pipe instantiates STAGES copies via generate.
REQ-036 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration with a fatal error.

Verification (WIDTH=32, STAGES=4, out_ready=1 unless stated)
REQ-037 ADD a=0x7FFFFFFF b=1 -> 4 cycles later sum=0x80000000, overflow=1, cout=0, neg=1, zero=0.
REQ-038 SUB a=5 b=5 -> sum=0, zero=1, cout=1, overflow=0; SUB a=0 b=1 -> sum=0xFFFFFFFF, cout=0, neg=1.
REQ-039 SUBS a=0x80000000 b=1 -> sum=0x80000000, overflow=1; ADDS a=0x7FFFFFF0 b=0x20 -> sum=0x7FFFFFFF, overflow=1.
REQ-040 16 back-to-back random beats, out_ready low cycles 6-9 -> in_ready low same cycles, outputs frozen, all 16 results correct and in order, no loss.
REQ-041 3 beats accepted, rst_n low 1 cycle at cycle 2 -> out_valid never asserts for them; new beat after release emerges 4 cycles later correct.
REQ-042 Carry crossing all slices: ADD a=0xFFFFFFFF b=1 -> sum=0, cout=1, zero=1, overflow=0.
